useq_fifo_bridge: RTL and testbench

//  Host-side mailbox bridge for the useq core's message FIFO port.

---
 rtl/useq_fifo_bridge.sv | 140 ++++++++++++++
 tb/tb_useq_fifo_bridge.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/useq_fifo_bridge.sv
// Mailbox bridge between a host valid/ready byte stream and the useq core's FIFO strobes.
// Write and read strobes are mutually exclusive, flag-gated, and followed by GAP idle cycles.
module useq_fifo_bridge #(
    parameter int GAP   = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    input  logic             fifo_empty,
    input  logic             fifo_full,
    input  logic [7:0]       fifo_out,
    output logic             write_fifo,
    output logic             read_fifo,
    output logic [7:0]       fifo_in,
    output logic [CNT_W-1:0] tx_count,
    output logic [CNT_W-1:0] rx_count
);

    typedef enum logic {
        SIDE_WR = 1'b0,
        SIDE_RD = 1'b1
    } side_e;

    logic             hold_valid_q, hold_valid_d;
    logic [7:0]       hold_data_q, hold_data_d;
    logic [7:0]       obuf_q [2];
    logic [7:0]       obuf_d [2];
    logic [1:0]       obuf_count_q, obuf_count_d;
    logic             rd_inflight_q, rd_inflight_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    side_e            last_grant_q, last_grant_d;
    logic [CNT_W-1:0] tx_count_q, tx_count_d;
    logic [CNT_W-1:0] rx_count_q, rx_count_d;

    logic wr_ok, rd_ok, wr_grant, rd_grant;
    logic s_load, m_pop;

    // Eligibility and arbitration use this cycle's core flags; useq samples the strobes at the same edge.
    always_comb begin
        wr_ok    = ~rst && (gap_cnt_q == 4'd0) && hold_valid_q && ~fifo_full;
        rd_ok    = ~rst && (gap_cnt_q == 4'd0) && ~fifo_empty
                   && ((obuf_count_q + {1'b0, rd_inflight_q}) < 2'd2);
        wr_grant = wr_ok && (~rd_ok || (last_grant_q == SIDE_RD));
        rd_grant = rd_ok && (~wr_ok || (last_grant_q == SIDE_WR));
    end

    assign s_ready    = ~rst & ~hold_valid_q;
    assign m_valid    = (obuf_count_q != 2'd0);
    assign m_data     = obuf_q[0];
    assign fifo_in    = hold_data_q;
    assign write_fifo = wr_grant;
    assign read_fifo  = rd_grant;
    assign tx_count   = tx_count_q;
    assign rx_count   = rx_count_q;
    assign s_load     = s_valid & s_ready;
    assign m_pop      = m_valid & m_ready;

    // NOTE: every _d gets its current value first so no path through this block leaves it unassigned (no latch).
    always_comb begin
        hold_valid_d  = hold_valid_q;
        hold_data_d   = hold_data_q;
        obuf_d        = obuf_q;
        obuf_count_d  = obuf_count_q;
        rd_inflight_d = rd_grant;
        gap_cnt_d     = gap_cnt_q;
        last_grant_d  = last_grant_q;
        tx_count_d    = tx_count_q;
        rx_count_d    = rx_count_q;

        // A load needs an empty hold, so it never coincides with a write strobe.
        if (s_load) begin
            hold_valid_d = 1'b1;
            hold_data_d  = s_data;
        end
        if (wr_grant) begin
            hold_valid_d = 1'b0;
            tx_count_d   = tx_count_q + CNT_W'(1);
        end
        if (rd_grant) begin
            rx_count_d = rx_count_q + CNT_W'(1);
        end

        if (wr_grant || rd_grant) begin
            gap_cnt_d    = 4'(GAP);
            last_grant_d = rd_grant ? SIDE_RD : SIDE_WR;
        end else if (gap_cnt_q != 4'd0) begin
            gap_cnt_d = gap_cnt_q - 4'd1;
        end

        // Head lives in entry 0; the rd_ok budget guarantees a capture never finds the buffer full.
        if (rd_inflight_q && m_pop) begin
            if (obuf_count_q == 2'd1) begin
                obuf_d[0] = fifo_out;
            end else begin
                obuf_d[0] = obuf_q[1];
                obuf_d[1] = fifo_out;
            end
        end else if (m_pop) begin
            obuf_d[0]    = obuf_q[1];
            obuf_count_d = obuf_count_q - 2'd1;
        end else if (rd_inflight_q) begin
            obuf_d[obuf_count_q[0]] = fifo_out;
            obuf_count_d            = obuf_count_q + 2'd1;
        end
    end

    // NOTE: state registers take only non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid_q  <= 1'b0;
            hold_data_q   <= 8'h00;
            // NOTE: the output buffer is reset because its head drives m_data, which must read 0 after reset.
            obuf_q[0]     <= 8'h00;
            obuf_q[1]     <= 8'h00;
            obuf_count_q  <= 2'd0;
            rd_inflight_q <= 1'b0;
            gap_cnt_q     <= 4'd0;
            last_grant_q  <= SIDE_RD;
            tx_count_q    <= '0;
            rx_count_q    <= '0;
        end else begin
            hold_valid_q  <= hold_valid_d;
            hold_data_q   <= hold_data_d;
            obuf_q        <= obuf_d;
            obuf_count_q  <= obuf_count_d;
            rd_inflight_q <= rd_inflight_d;
            gap_cnt_q     <= gap_cnt_d;
            last_grant_q  <= last_grant_d;
            tx_count_q    <= tx_count_d;
            rx_count_q    <= rx_count_d;
        end
    end

endmodule

// File: tb/tb_useq_fifo_bridge.sv
// Self-checking bench for useq_fifo_bridge: models the useq FIFO port and scoreboards both byte streams.
// Expected tx bytes are queued on host handshake, expected rx bytes when the core FIFO is preloaded.
module tb_useq_fifo_bridge;

    localparam int GAP   = 1;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic [7:0]       s_data;
    logic             s_valid;
    logic             s_ready;
    logic [7:0]       m_data;
    logic             m_valid;
    logic             m_ready;
    logic             fifo_empty;
    logic             fifo_full;
    logic [7:0]       fifo_out;
    logic             write_fifo;
    logic             read_fifo;
    logic [7:0]       fifo_in;
    logic [CNT_W-1:0] tx_count;
    logic [CNT_W-1:0] rx_count;

    useq_fifo_bridge #(.GAP(GAP), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fifo_out   (fifo_out),
        .write_fifo (write_fifo),
        .read_fifo  (read_fifo),
        .fifo_in    (fifo_in),
        .tx_count   (tx_count),
        .rx_count   (rx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] src_q[$];
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    int         wr_cyc[$];
    int         grant_seq[$];
    int         cyc    = 0;
    int         wr_n   = 0;
    int         rd_n   = 0;
    bit         rec    = 0;
    bit         pend_rd = 0;

    always @(posedge clk) cyc++;

    // Sample mid-cycle: everything seen here takes effect at the coming rising edge.
    always @(negedge clk) begin
        pend_rd = 0;
        if (!rst) begin
            if (write_fifo || read_fifo)
                check("strobe_excl", 32'(write_fifo & read_fifo), 32'd0);
            if (write_fifo) begin
                wr_n++;
                wr_cyc.push_back(cyc);
                if (rec) grant_seq.push_back(1);
                if (tx_exp.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
                else check("fifo_in", 32'(fifo_in), 32'(tx_exp.pop_front()));
            end
            if (read_fifo) begin
                rd_n++;
                if (rec) grant_seq.push_back(0);
                check("rd_while_empty", 32'(fifo_empty), 32'd0);
                pend_rd = 1;
            end
            if (m_valid && m_ready) begin
                if (rx_exp.size() == 0) check("rx_unexpected", 32'd1, 32'd0);
                else check("m_data", 32'(m_data), 32'(rx_exp.pop_front()));
            end
            if (s_valid && s_ready) tx_exp.push_back(s_data);
        end
    end

    // Core FIFO model: a popped byte appears on fifo_out the cycle after the read strobe.
    always @(posedge clk) begin
        #1;
        if (pend_rd && src_q.size() != 0) fifo_out = src_q.pop_front();
        fifo_empty = (src_q.size() == 0);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic preload(input logic [7:0] b);
        src_q.push_back(b);
        rx_exp.push_back(b);
        fifo_empty = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int waited = 0;
        s_data  = b;
        s_valid = 1'b1;
        do begin
            @(negedge clk);
            waited++;
        end while (!s_ready && waited < 100);
        if (!s_ready) check("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #3;
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while ((tx_exp.size() != 0 || rx_exp.size() != 0 || m_valid) && waited < 300) begin
            tick(1);
            waited++;
        end
        check("drain_timeout", 32'(waited >= 300), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_s_ready",  32'(s_ready),    32'd0);
        check("rst_m_valid",  32'(m_valid),    32'd0);
        check("rst_write",    32'(write_fifo), 32'd0);
        check("rst_read",     32'(read_fifo),  32'd0);
        check("rst_tx_count", 32'(tx_count),   32'd0);
        check("rst_rx_count", 32'(rx_count),   32'd0);
        check("rst_m_data",   32'(m_data),     32'd0);
        check("rst_fifo_in",  32'(fifo_in),    32'd0);
        tx_exp.delete();
        rx_exp.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rel_s_ready", 32'(s_ready), 32'd1);
    endtask

    initial begin
        int rd0;
        int wr0;
        int waited;
        rst        = 1'b1;
        s_data     = 8'h00;
        s_valid    = 1'b0;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        fifo_full  = 1'b0;
        fifo_out   = 8'h00;

        // Idle after reset: no strobes, s_ready high, nothing to read.
        do_reset();
        tick(12);
        check("idle_s_ready", 32'(s_ready), 32'd1);
        check("idle_m_valid", 32'(m_valid), 32'd0);
        check("idle_writes",  32'(wr_n),    32'd0);
        check("idle_reads",   32'(rd_n),    32'd0);

        // Three bytes, write strobes spaced GAP+1 cycles apart.
        wr_cyc.delete();
        send(8'h11);
        send(8'h22);
        send(8'h33);
        drain();
        check("t2_writes",   32'(wr_cyc.size()), 32'd3);
        if (wr_cyc.size() == 3) begin
            check("t2_spacing0", 32'(wr_cyc[1] - wr_cyc[0]), 32'(GAP + 1));
            check("t2_spacing1", 32'(wr_cyc[2] - wr_cyc[1]), 32'(GAP + 1));
        end
        check("t2_tx_count", 32'(tx_count), 32'd3);

        // Core full: byte held with backpressure, then written once the core has room.
        fifo_full = 1'b1;
        wr0 = wr_n;
        send(8'hAA);
        tick(6);
        check("t3_s_ready", 32'(s_ready),    32'd0);
        check("t3_write",   32'(write_fifo), 32'd0);
        check("t3_held",    32'(wr_n - wr0), 32'd0);
        fifo_full = 1'b0;
        drain();
        check("t3_written", 32'(wr_n - wr0), 32'd1);
        check("t3_tx_count", 32'(tx_count),  32'd4);

        // Both sides eligible: grants alternate.
        grant_seq.delete();
        m_ready = 1'b1;
        rec     = 1'b1;
        for (int i = 0; i < 8; i++) preload(8'h40 + 8'(i));
        for (int i = 0; i < 8; i++) send(8'h80 + 8'(i));
        drain();
        rec = 1'b0;
        check("t4_grants", 32'(grant_seq.size()), 32'd16);
        for (int i = 1; i < 12 && i < grant_seq.size(); i++)
            check("t4_alternate", 32'(grant_seq[i] != grant_seq[i-1]), 32'd1);

        // Host stalled: exactly two reads fill the output buffer, then drain in order.
        m_ready = 1'b0;
        do_reset();
        rd0 = rd_n;
        for (int i = 1; i <= 4; i++) preload(8'(i));
        tick(12);
        check("t5_reads_stalled", 32'(rd_n - rd0), 32'd2);
        check("t5_m_valid",       32'(m_valid),    32'd1);
        check("t5_head",          32'(m_data),     32'h01);
        m_ready = 1'b1;
        drain();
        check("t5_reads",    32'(rd_n - rd0), 32'd4);
        check("t5_rx_count", 32'(rx_count),   32'd4);

        // Reset right after a read strobe drops the in-flight byte.
        m_ready = 1'b0;
        preload(8'h55);
        preload(8'h66);
        preload(8'h77);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!read_fifo && waited < 20);
        check("t6_read_seen", 32'(read_fifo), 32'd1);
        do_reset();
        rx_exp = src_q;
        m_ready = 1'b1;
        drain();
        check("t6_rx_count", 32'(rx_count), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
